uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmit controller between NUM_REQ byte requesters.
- Each requester presents a byte. The arbiter grants one requester, latches its byte and acknowledges it.
- It then drives the transmitter's send_en/Din handshake and waits for the transmitter's busy to rise and fall before the next grant.
- Sits between the packet/command sources and the UART TX controller on the 50 MHz domain.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and TX-controller handshake bundle for uart_tx_arbiter
//   req_valid/req_data/req_ack : NUM_REQ byte requesters (byte i at req_data[8i+7:8i])
//   grant_id                   : index of the last/current granted requester
//   tx_send_en/tx_din/tx_busy  : UART TX controller send handshake
//   arb_busy/timeout_err       : arbiter status
//   master = requesters + TX controller side, slave = arbiter side
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int GID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ack;
  logic [GID_W-1:0] grant_id;
  logic tx_send_en;
  logic [7:0] tx_din;
  logic tx_busy;
  logic arb_busy;
  logic timeout_err;
  modport master (
    output req_valid, req_data, tx_busy,
    input req_ack, grant_id, tx_send_en, tx_din, arb_busy, timeout_err
  );
  modport slave (
    input req_valid, req_data, tx_busy,
    output req_ack, grant_id, tx_send_en, tx_din, arb_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX controller among NUM_REQ byte requesters
//   CLK_50M : 50 MHz clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : uart_tx_arbiter_if.slave (requester handshake, TX controller handshake, status)
//   Optional macro TX_ARB_TIMEOUT_EN: abort LAUNCH after LAUNCH_TIMEOUT cycles without tx_busy,
//   setting sticky timeout_err; without it LAUNCH waits forever and timeout_err is tied low.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GID_W = 2,
  parameter int LAUNCH_TIMEOUT = 1023
) (
  input logic CLK_50M,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || GID_W < $clog2(NUM_REQ) || LAUNCH_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter combination");
  end
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win, idx;
  logic [7:0] tx_din_q, tx_din_d, win_data;
  logic send_en_q, send_en_d, found;
  logic [NUM_REQ-1:0] ack_q, ack_d;
`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_err_q, timeout_err_d;
`endif
  // Scan downwards so the requester closest to rr_ptr (smallest offset) is the last writer and wins.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    win_data = 8'(bus.req_data >> {win, 3'b000});
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_din_d = tx_din_q;
    send_en_d = send_en_q;
    ack_d = '0;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: if (!bus.tx_busy && found) begin
        tx_din_d = win_data;
        send_en_d = 1'b1;
        ack_d = NUM_REQ'(1) << win;
        grant_id_d = win;
        rr_ptr_d = win == GID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
        state_d = LAUNCH;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      LAUNCH: if (bus.tx_busy) begin
        send_en_d = 1'b0;
        state_d = WAIT_DONE;
      end
`ifdef TX_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(LAUNCH_TIMEOUT - 1)) begin
        send_en_d = 1'b0;
        timeout_err_d = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
`endif
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      tx_din_q <= '0;
      send_en_q <= 1'b0;
      ack_q <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_din_q <= tx_din_d;
      send_en_q <= send_en_d;
      ack_q <= ack_d;
`ifdef TX_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end
  assign bus.req_ack = ack_q;
  assign bus.grant_id = grant_id_q;
  assign bus.tx_send_en = send_en_q;
  assign bus.tx_din = tx_din_q;
  assign bus.arb_busy = state_q != IDLE;
`ifdef TX_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized check of uart_tx_arbiter against a round-robin reference model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int rr_m = 0;
  bit err_m = 1'b0;
  always #10 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(4), .GID_W(2)) bus ();
  uart_tx_arbiter #(.NUM_REQ(4), .GID_W(2), .LAUNCH_TIMEOUT(16)) dut (
    .CLK_50M(clk),
    .reset(rst),
    .bus(bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int winner(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[(rr_m + k) % 4]) return (rr_m + k) % 4;
    return -1;
  endfunction
  task automatic grant_checks(input int w, input logic [7:0] b);
    check("ack", bus.req_ack, 1 << w);
    check("grant_id", bus.grant_id, w);
    check("tx_din", bus.tx_din, b);
    check("send_en_launch", bus.tx_send_en, 1);
    check("arb_busy_launch", bus.arb_busy, 1);
    check("timeout_err", bus.timeout_err, err_m);
  endtask
  // One frame: present requests, then a TX controller that raises busy `rise` cycles after
  // send_en appears and holds it for `hold` cycles.
  task automatic frame(input logic [3:0] v, input logic [31:0] d, input int rise, input int hold);
    int w;
    logic [7:0] b;
    bus.req_valid = v;
    bus.req_data = d;
    w = winner(v);
    tick();
    if (w < 0) begin
      check("idle_ack", bus.req_ack, 0);
      check("idle_arb_busy", bus.arb_busy, 0);
      return;
    end
    b = d[8*w +: 8];
    rr_m = (w + 1) % 4;
    grant_checks(w, b);
    for (int j = 0; j < rise; j++) begin
      tick();
      check("send_en_wait", bus.tx_send_en, 1);
      check("ack_one_cycle", bus.req_ack, 0);
    end
    bus.tx_busy = 1'b1;
    for (int j = 0; j < hold; j++) begin
      tick();
      check("send_en_busy", bus.tx_send_en, 0);
      check("arb_busy_busy", bus.arb_busy, 1);
      check("tx_din_hold", bus.tx_din, b);
    end
    bus.tx_busy = 1'b0;
    tick();
    check("arb_busy_done", bus.arb_busy, 0);
    check("send_en_done", bus.tx_send_en, 0);
    check("tx_din_done", bus.tx_din, b);
    check("grant_id_hold", bus.grant_id, w);
    check("timeout_err_done", bus.timeout_err, err_m);
  endtask
  initial begin
    int w;
    logic [31:0] d;
    bus.req_valid = 4'b1111;
    bus.req_data = 32'h44332211;
    bus.tx_busy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("rst_ack", bus.req_ack, 0);
      check("rst_send_en", bus.tx_send_en, 0);
      check("rst_arb_busy", bus.arb_busy, 0);
      check("rst_grant_id", bus.grant_id, 0);
      check("rst_tx_din", bus.tx_din, 0);
      check("rst_timeout_err", bus.timeout_err, 0);
    end
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      w = winner(4'b1111);
      check("rr_order", w, j % 4);
      frame(4'b1111, 32'h44332211, 1, 3);
    end
    frame(4'b0100, 32'h00AC0000, 2, 10);
    frame(4'b1000, 32'h5A000000, 1, 2);
    w = winner(4'b0101);
    check("wrap_to_0", w, 0);
    frame(4'b0101, 32'h00C300B7, 1, 2);
    frame(4'b0101, 32'h00C300B7, 1, 2);
    frame(4'b0001, 32'h000000E1, 0, 1);
    frame(4'b0001, 32'h000000E2, 0, 1);
    bus.tx_busy = 1'b1;
    bus.req_valid = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("ext_busy_ack", bus.req_ack, 0);
      check("ext_busy_arb", bus.arb_busy, 0);
    end
    bus.tx_busy = 1'b0;
    frame(4'b0001, 32'h0000007E, 1, 4);
    bus.req_valid = 4'b1000;
    bus.req_data = 32'h9D000000;
    w = winner(4'b1000);
    tick();
    rr_m = (w + 1) % 4;
    grant_checks(w, 8'h9D);
    bus.req_valid = 4'b0000;
    bus.tx_busy = 1'b1;
    tick();
    check("wd_send_en", bus.tx_send_en, 0);
    check("wd_arb_busy", bus.arb_busy, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_send_en", bus.tx_send_en, 0);
    check("mid_rst_arb_busy", bus.arb_busy, 0);
    check("mid_rst_grant_id", bus.grant_id, 0);
    check("mid_rst_tx_din", bus.tx_din, 0);
    rst = 1'b0;
    bus.tx_busy = 1'b0;
    rr_m = 0;
    err_m = 1'b0;
    tick();
    frame(4'b1010, 32'h00F000E0, 1, 2);
    for (int n = 0; n < 40; n++)
      frame(4'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(1, 6));
    bus.req_valid = 4'b0010;
    d = $urandom;
    bus.req_data = d;
    w = winner(4'b0010);
    tick();
    rr_m = (w + 1) % 4;
    grant_checks(w, d[15:8]);
    bus.req_valid = 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("to_send_en", bus.tx_send_en, j <= 15);
      check("to_err", bus.timeout_err, j >= 16);
      check("to_arb_busy", bus.arb_busy, j <= 15);
    end
    err_m = 1'b1;
`else
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("no_to_send_en", bus.tx_send_en, 1);
      check("no_to_err", bus.timeout_err, 0);
    end
    bus.tx_busy = 1'b1;
    tick();
    check("no_to_drop", bus.tx_send_en, 0);
    bus.tx_busy = 1'b0;
    tick();
    check("no_to_idle", bus.arb_busy, 0);
`endif
    frame(4'b0001, 32'h00000066, 1, 2);
    frame(4'b1100, 32'h77880000, 2, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
